s1_serial_node: RTL
===================

Name: s1_serial_node

Overview:
- Initiator end of the S1/S2 serial link.
- Reads the 18x8 RB1 register bank and transposes it into eight 21-bit frames (3-bit address + 18-bit data), then shifts them to S2 over sen/sd.
- Releases the bus and waits for S2_done, then receives eighteen 13-bit frames (5-bit address + 8-bit data) from S2 and writes them back into RB1.
- A full round trip leaves RB1 unchanged; S1_done marks completion.

Parameters:
- RB1_WORDS, 18, RB1 depth and number of receive frames.
- RB1_WIDTH, 8, RB1 word width and number of transmit frames.
- TX_ADDR_W, 3, transmit frame address width.
- RX_ADDR_W, 5, receive frame address width and RB1 address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- S2_done  in  1  one-cycle pulse from S2: its RB2 write phase is complete.
- S1_done  out  1  one-cycle pulse when the last RB1 write-back is issued.
- RB1_RW  out  1  1=read, 0=write (write takes effect at the next rising edge).
- RB1_A  out  5  RB1 address.
- RB1_D  out  8  RB1 write data.
- RB1_Q  in  8  RB1 read data, valid one cycle after RB1_A is presented.
- sen  inout  1  frame enable, active low; driven by the current bus owner.
- sd  inout  1  serial data, MSB first; sampled on rising clk while sen==0.

Behaviour:
- Reset (synchronous, active-high): state=LOAD, S1_done=0, RB1_RW=1, RB1_A=0, RB1_D=0, S1 drives sen=1 and sd=0, all counters cleared. Asserting rst in any state aborts at once; no partial RB1 write is issued on the reset cycle.
- LOAD: issue reads at addresses 0..17 on consecutive cycles. Capture RB1_Q one cycle later into buf[0..17]. Takes 19 cycles in total, then go to TX.
- TX, frame i = 0..7:
  - Drive sen=0 for exactly 21 consecutive cycles.
  - sd bit order: i[2:0] MSB first, then buf[0][i], buf[1][i], ..., buf[17][i].
  - So S2 data bit (17-j) = RB1[j][i].
- TX_GAP: sen=1, sd=0 for exactly 1 cycle after each frame. After frame 7, go to WAIT.
- WAIT:
  - sen and sd go to Z (S2 becomes bus owner).
  - Go to RX on the cycle S2_done==1.
  - A S2_done pulse in any other state is ignored.
- RX:
  - sen and sd stay Z.
  - On each rising edge with sen==0, shift sd into a 13-bit register and increment the bit count.
  - After 13 bits: addr=sh[12:8], data=sh[7:0]. Go to RX_WR on the next cycle.
  - If sen returns to 1 with bit count between 1 and 12, discard the partial frame and clear the count; nothing is written.
- RX_WR, one cycle:
  - If addr<18: RB1_RW=0, RB1_A=addr, RB1_D=data, and increment frame count.
  - If addr>=18: no write and no count.
  - Return to RX. A sen==0 bit in this cycle is still sampled as bit 1 of the next frame.
- When frame count reaches 18: S1_done=1 for the cycle of the final write, then go to HALT.
- HALT: sen and sd Z, RB1_RW=1, stay until rst.
- Duplicate receive addresses overwrite the earlier value. Every frame with an in-range address counts toward 18, so 18 frames are needed in total.
- Counter widths: TX bit 5b, TX frame 3b, RX bit 4b, RX frame 5b. No counter wraps in normal operation.

Decomposition:
- Shared package s1s2_link_pkg holds:
  - constants TX_FRAME_BITS=21, RX_FRAME_BITS=13, TX_FRAMES=8, RX_FRAMES=18;
  - the state enum LOAD/TX/TX_GAP/WAIT/RX/RX_WR/HALT.
- One sub-module, s1_rx_deframer: 13-bit shift register, bit counter, abort on early sen rise, frame_valid/addr/data outputs.
- TX path and control FSM stay in the top level.

Test Plan:
- Load RB1[j]=j*8'h11 (wrapped), release rst -> 19-cycle read sweep 0..17, then frame 0 on sd = 000 followed by bit0 of RB1[0..17]; sen low exactly 21 cycles, 1-cycle gap, 8 frames total.
- After frame 7 -> sen/sd at Z. Pulse S2_done mid-TX -> ignored. Pulse in WAIT -> RX entered the next cycle.
- Bench S2 model sends 18 frames, addr k and data 8'hA5^k -> RB1[k]=8'hA5^k. S1_done is a single pulse coincident with the k=17 write.
- Inject frame with addr 5'd20 -> no RB1 write, not counted. Inject a 7-bit frame aborted by sen=1 -> discarded; the following full frame is written correctly.
- Full loopback with the S2 model: RB1 after the cycle is identical to its initial contents for patterns 8'h00, 8'hFF, and random.
- Assert rst during TX frame 4 and during RX frame 10 -> next cycle state is LOAD, sen=1, RB1_RW=1; the sequence restarts from address 0.

Source files
------------

// File: rtl/s1s2_link_pkg.sv
// Shared constants and controller state encoding for the S1/S2 serial link.
package s1s2_link_pkg;
  localparam int RB1_WORDS     = 18;
  localparam int RB1_WIDTH     = 8;
  localparam int TX_ADDR_W     = 3;
  localparam int RX_ADDR_W     = 5;
  localparam int TX_FRAME_BITS = 21;
  localparam int RX_FRAME_BITS = 13;
  localparam int TX_FRAMES     = 8;
  localparam int RX_FRAMES     = 18;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    TX     = 3'd1,
    TX_GAP = 3'd2,
    WAIT   = 3'd3,
    RX     = 3'd4,
    RX_WR  = 3'd5,
    HALT   = 3'd6
  } link_state_t;
endpackage

// File: rtl/s1_serial_node_if.sv
// RB1 register-bank port plus the S2_done/S1_done completion handshake.
interface s1_serial_node_if;
  import s1s2_link_pkg::*;

  logic                 S2_done;
  logic                 S1_done;
  logic                 RB1_RW;
  logic [RX_ADDR_W-1:0] RB1_A;
  logic [RB1_WIDTH-1:0] RB1_D;
  logic [RB1_WIDTH-1:0] RB1_Q;

  modport master (input S2_done, RB1_Q, output S1_done, RB1_RW, RB1_A, RB1_D);
  modport slave  (output S2_done, RB1_Q, input S1_done, RB1_RW, RB1_A, RB1_D);
endinterface

// File: rtl/s1_rx_deframer.sv
// Collects 13-bit receive frames; frame_valid/addr/data describe the frame whose
// last bit is being sampled on the coming edge, so the write can be registered then.
module s1_rx_deframer
  import s1s2_link_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sen,
  input  logic                 sd,
  output logic                 frame_valid,
  output logic [RX_ADDR_W-1:0] addr,
  output logic [RB1_WIDTH-1:0] data
);
  logic [RX_FRAME_BITS-2:0] sh_r;
  logic [3:0]               cnt_r;
  logic [RX_FRAME_BITS-1:0] word_s;

  // The live sd bit completes the 13-bit shift register contents.
  assign word_s      = {sh_r, sd};
  assign frame_valid = en & ~sen & (cnt_r == 4'(RX_FRAME_BITS - 1));
  assign addr        = word_s[RX_FRAME_BITS-1:RB1_WIDTH];
  assign data        = word_s[RB1_WIDTH-1:0];

  // Shift while sen is low; an early sen rise drops a partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_r  <= '0;
      cnt_r <= 4'd0;
    end else if (!en || sen) begin
      cnt_r <= 4'd0;
    end else begin
      sh_r  <= word_s[RX_FRAME_BITS-2:0];
      cnt_r <= frame_valid ? 4'd0 : cnt_r + 4'd1;
    end
  end
endmodule

// File: rtl/s1_serial_node.sv
// S1 link initiator: snapshot RB1, ship it transposed to S2, then accept the
// returning frames and write them back into RB1.
module s1_serial_node
  import s1s2_link_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  inout  wire                 sen,
  inout  wire                 sd,
  s1_serial_node_if.master    bus
);
  link_state_t          state_r;
  logic [4:0]           ld_cnt_r;
  logic [4:0]           tx_bit_r;
  logic [2:0]           tx_frm_r;
  logic [4:0]           rx_frm_r;
  logic [RB1_WIDTH-1:0] rb_buf_r [RB1_WORDS];
  logic                 drive_r;
  logic                 sen_r;
  logic                 sd_r;
  logic                 rw_r;
  logic                 done_r;
  logic [RX_ADDR_W-1:0] a_r;
  logic [RB1_WIDTH-1:0] d_r;
  logic                 rx_en_s;
  logic                 rx_valid_s;
  logic [RX_ADDR_W-1:0] rx_addr_s;
  logic [RB1_WIDTH-1:0] rx_data_s;

  assign sen = drive_r ? sen_r : 1'bz;
  assign sd  = drive_r ? sd_r  : 1'bz;

  // Reset overrides the registered strobe so a write cannot land on the reset edge.
  assign bus.RB1_RW  = rw_r | rst;
  assign bus.RB1_A   = a_r;
  assign bus.RB1_D   = d_r;
  assign bus.S1_done = done_r;

  assign rx_en_s = (state_r == RX) || (state_r == RX_WR);

  s1_rx_deframer u_rx (
    .clk         (clk),
    .rst         (rst),
    .en          (rx_en_s),
    .sen         (sen),
    .sd          (sd),
    .frame_valid (rx_valid_s),
    .addr        (rx_addr_s),
    .data        (rx_data_s)
  );

  // Bit idx of transmit frame frm: 3 address bits, then bit frm of buf[0..17].
  function automatic logic tx_bit_f(input logic [2:0] frm, input logic [4:0] idx);
    if (idx < 5'(TX_ADDR_W)) begin
      tx_bit_f = frm[2'd2 - idx[1:0]];
    end else begin
      tx_bit_f = rb_buf_r[idx - 5'(TX_ADDR_W)][frm];
    end
  endfunction

  // Capture read data one cycle behind the address sweep.
  always_ff @(posedge clk) begin
    if (!rst && state_r == LOAD && ld_cnt_r != 5'd0) begin
      rb_buf_r[ld_cnt_r - 5'd1] <= bus.RB1_Q;
    end
  end

  // Control FSM with registered bus and serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= LOAD;
      ld_cnt_r <= 5'd0;
      tx_bit_r <= 5'd0;
      tx_frm_r <= 3'd0;
      rx_frm_r <= 5'd0;
      drive_r  <= 1'b1;
      sen_r    <= 1'b1;
      sd_r     <= 1'b0;
      rw_r     <= 1'b1;
      done_r   <= 1'b0;
      a_r      <= 5'd0;
      d_r      <= 8'd0;
    end else begin
      rw_r   <= 1'b1;
      done_r <= 1'b0;
      case (state_r)
        LOAD: begin
          if (ld_cnt_r == 5'(RB1_WORDS)) begin
            state_r  <= TX;
            tx_bit_r <= 5'd0;
            tx_frm_r <= 3'd0;
            sen_r    <= 1'b0;
            sd_r     <= tx_bit_f(3'd0, 5'd0);
          end else begin
            ld_cnt_r <= ld_cnt_r + 5'd1;
            if (ld_cnt_r < 5'(RB1_WORDS - 1)) begin
              a_r <= ld_cnt_r + 5'd1;
            end
          end
        end
        TX: begin
          if (tx_bit_r == 5'(TX_FRAME_BITS - 1)) begin
            state_r <= TX_GAP;
            sen_r   <= 1'b1;
            sd_r    <= 1'b0;
          end else begin
            tx_bit_r <= tx_bit_r + 5'd1;
            sd_r     <= tx_bit_f(tx_frm_r, tx_bit_r + 5'd1);
          end
        end
        TX_GAP: begin
          if (tx_frm_r == 3'(TX_FRAMES - 1)) begin
            state_r <= WAIT;
            drive_r <= 1'b0;
          end else begin
            state_r  <= TX;
            tx_frm_r <= tx_frm_r + 3'd1;
            tx_bit_r <= 5'd0;
            sen_r    <= 1'b0;
            sd_r     <= tx_bit_f(tx_frm_r + 3'd1, 5'd0);
          end
        end
        WAIT: begin
          if (bus.S2_done) begin
            state_r <= RX;
          end
        end
        RX: begin
          if (rx_valid_s) begin
            state_r <= RX_WR;
            if (rx_addr_s < 5'(RB1_WORDS)) begin
              rw_r     <= 1'b0;
              a_r      <= rx_addr_s;
              d_r      <= rx_data_s;
              rx_frm_r <= rx_frm_r + 5'd1;
              done_r   <= (rx_frm_r == 5'(RX_FRAMES - 1));
            end
          end
        end
        RX_WR: begin
          state_r <= (rx_frm_r == 5'(RX_FRAMES)) ? HALT : RX;
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end
endmodule
